// File: rtl/burst_sched_pkg.sv
// Shared types and constants for the burst_sched gated-carrier sequencer.
package burst_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      FIN  = 2'd3
   } state_e;

   localparam logic [1:0] ADDR_PERIOD = 2'd0;
   localparam logic [1:0] ADDR_HIGH   = 2'd1;
   localparam logic [1:0] ADDR_ON     = 2'd2;
   localparam logic [1:0] ADDR_TOTAL  = 2'd3;

   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/burst_carrier.sv
// Free-running carrier: period counter, high-time compare and period-end tick.
module burst_carrier #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] high,
   output logic             carrier,
   output logic             tick
);

   logic [CNT_W-1:0] pc_q, pc_d;

   assign tick    = en && (pc_q == period - CNT_W'(1));
   // A high time at or above the period keeps the carrier high for the whole period.
   assign carrier = en && (pc_q < high);

   always_comb begin
      pc_d = pc_q;
      if (clr)     pc_d = '0;
      else if (en) pc_d = tick ? '0 : pc_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only; the reset here is synchronous.
   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

endmodule

// File: rtl/burst_sched.sv
// Burst sequencer: register file, IDLE/ON/OFF/FIN FSM, window and burst counters.
// Optional macro BURST_SCHED_SOFT_STOP_EN turns stop into a finish-current-burst request.
module burst_sched
   import burst_sched_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int DEF_PERIOD = 1316,
   parameter int DEF_HIGH   = 330,
   parameter int DEF_ON     = 21,
   parameter int DEF_TOTAL  = 84
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   input  logic             start,
   input  logic             stop,
   input  logic [7:0]       burst_num,
   output logic             busy,
   output logic             done,
   output logic             carrier,
   output logic             window,
   output logic             z
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] period_q, period_d, high_q, high_d, on_q, on_d, total_q, total_d;
   logic [CNT_W-1:0] s_period_q, s_period_d, s_high_q, s_high_d;
   logic [CNT_W-1:0] s_on_q, s_on_d, s_total_q, s_total_d;
   logic [CNT_W-1:0] wc_q, wc_d;
   logic [7:0]       bn_q, bn_d, bc_q, bc_d;
   logic             z_q, z_d;

   logic [CNT_W-1:0] period_c, total_c, on_c;
   logic             active, tick, burst_end, last_burst;
   logic             start_ok, hard_stop, finish;

   assign period_c = (period_q < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_q;
   assign total_c  = (total_q == '0) ? CNT_W'(1) : total_q;
   assign on_c     = (on_q > total_c) ? total_c : on_q;

   assign active     = (state_q == ON) || (state_q == OFF);
   assign burst_end  = tick && (wc_q == s_total_q - CNT_W'(1));
   assign last_burst = (bn_q != 8'd0) && (bc_q + 8'd1 == bn_q);

`ifdef BURST_SCHED_SOFT_STOP_EN
   logic stop_pend_q, stop_pend_d;

   assign start_ok  = (state_q == IDLE) && start;
   assign hard_stop = 1'b0;
   assign finish    = last_burst || stop_pend_q || stop;

   always_comb begin
      stop_pend_d = stop_pend_q;
      if (state_q == IDLE)      stop_pend_d = 1'b0;
      else if (active && stop)  stop_pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) stop_pend_q <= 1'b0;
      else     stop_pend_q <= stop_pend_d;
   end
`else
   assign start_ok  = (state_q == IDLE) && start && !stop;
   assign hard_stop = active && stop;
   assign finish    = last_burst;
`endif

   burst_carrier #(.CNT_W(CNT_W)) u_carrier (
      .clk     (clk),
      .rst     (rst),
      .en      (active),
      .clr     (start_ok),
      .period  (s_period_q),
      .high    (s_high_q),
      .carrier (carrier),
      .tick    (tick)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      period_d   = period_q;
      high_d     = high_q;
      on_d       = on_q;
      total_d    = total_q;
      s_period_d = s_period_q;
      s_high_d   = s_high_q;
      s_on_d     = s_on_q;
      s_total_d  = s_total_q;
      wc_d       = wc_q;
      bn_d       = bn_q;
      bc_d       = bc_q;
      state_d    = state_q;

      if (state_q == IDLE && cfg_we) begin
         case (cfg_addr)
            ADDR_PERIOD: period_d = cfg_wdata;
            ADDR_HIGH:   high_d   = cfg_wdata;
            ADDR_ON:     on_d     = cfg_wdata;
            ADDR_TOTAL:  total_d  = cfg_wdata;
            default:     ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               // The running sequence works only from these clamped copies.
               s_period_d = period_c;
               s_high_d   = high_q;
               s_on_d     = on_c;
               s_total_d  = total_c;
               bn_d       = burst_num;
               bc_d       = 8'd0;
               wc_d       = '0;
               state_d    = (on_c == '0) ? OFF : ON;
            end
         end
         ON, OFF: begin
            if (hard_stop) begin
               state_d = FIN;
            end else if (burst_end) begin
               wc_d    = '0;
               bc_d    = bc_q + 8'd1;
               state_d = finish ? FIN : ((s_on_q == '0) ? OFF : ON);
            end else if (tick) begin
               wc_d = wc_q + CNT_W'(1);
               if (state_q == ON && wc_q == s_on_q - CNT_W'(1)) state_d = OFF;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      z_d = carrier && window && !hard_stop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         period_q   <= CNT_W'(DEF_PERIOD);
         high_q     <= CNT_W'(DEF_HIGH);
         on_q       <= CNT_W'(DEF_ON);
         total_q    <= CNT_W'(DEF_TOTAL);
         s_period_q <= '0;
         s_high_q   <= '0;
         s_on_q     <= '0;
         s_total_q  <= '0;
         wc_q       <= '0;
         bn_q       <= 8'd0;
         bc_q       <= 8'd0;
         z_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         high_q     <= high_d;
         on_q       <= on_d;
         total_q    <= total_d;
         s_period_q <= s_period_d;
         s_high_q   <= s_high_d;
         s_on_q     <= s_on_d;
         s_total_q  <= s_total_d;
         wc_q       <= wc_d;
         bn_q       <= bn_d;
         bc_q       <= bc_d;
         z_q        <= z_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FIN);
   assign window = (state_q == ON);
   assign z      = z_q;

endmodule
